// File: rtl/tcu_priv_timer_sched_pkg.sv
// Shared constants and types for the privileged timer scheduler and its countdown timer.
package tcu_priv_timer_sched_pkg;

    localparam int unsigned TIMER_SIZE   = 32;
    localparam int unsigned CLKFREQ_MHZ  = 100;
    localparam int unsigned NUM_SLOTS    = 8;
    localparam int unsigned SLOT_W       = $clog2(NUM_SLOTS);
    localparam int unsigned TIMER_FACTOR = 1000 / CLKFREQ_MHZ;
    // Covers one full scan plus the early-fire tolerance of the countdown timer.
    localparam int unsigned SLACK        = TIMER_FACTOR * (NUM_SLOTS + 4);

    // Value 0 cancels a slot on cfg and stops the countdown timer on program.
    localparam logic [TIMER_SIZE-1:0] VALUE_STOP = '0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCAN    = 2'd1,
        ST_PROGRAM = 2'd2,
        ST_FIRE    = 2'd3
    } state_e;

endpackage

// File: rtl/tcu_priv_timer_slots.sv
// Per-slot armed/deadline/pending storage with indexed read and lowest-pending encoder.
module tcu_priv_timer_slots
    import tcu_priv_timer_sched_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  wr_en,
    input  logic [SLOT_W-1:0]     wr_slot,
    input  logic                  wr_arm,
    input  logic [TIMER_SIZE-1:0] wr_deadline,
    input  logic                  exp_en,
    input  logic [SLOT_W-1:0]     exp_slot,
    input  logic                  ack_en,
    input  logic [SLOT_W-1:0]     ack_slot,
    input  logic [SLOT_W-1:0]     rd_slot,
    output logic                  rd_armed_c,
    output logic [TIMER_SIZE-1:0] rd_deadline_c,
    output logic                  pend_any_c,
    output logic [SLOT_W-1:0]     pend_lowest_c
);

    logic [NUM_SLOTS-1:0]  armed_q;
    logic [NUM_SLOTS-1:0]  pending_q;
    logic [NUM_SLOTS-1:0]  pend_rest;
    logic [TIMER_SIZE-1:0] deadline_q [NUM_SLOTS];

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            armed_q   <= '0;
            pending_q <= '0;
        end else begin
            if (wr_en) armed_q[wr_slot] <= wr_arm;
            if (exp_en) begin
                armed_q[exp_slot]   <= 1'b0;
                pending_q[exp_slot] <= 1'b1;
            end
            if (ack_en) pending_q[ack_slot] <= 1'b0;
        end
    end

    // Deadlines are only meaningful while armed, so they need no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) deadline_q[wr_slot] <= wr_deadline;
    end

    assign rd_armed_c    = armed_q[rd_slot];
    assign rd_deadline_c = deadline_q[rd_slot];

    // Priority view excludes the slot being acknowledged so the next one is ready at once.
    always_comb begin
        pend_rest = pending_q;
        if (ack_en) pend_rest[ack_slot] = 1'b0;
        pend_lowest_c = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (pend_rest[i]) pend_lowest_c = SLOT_W'(i);
        end
    end

    assign pend_any_c = |pend_rest;

endmodule

// File: rtl/tcu_priv_timer_sched.sv
// Multiplexes per-activity software timers onto the single privileged countdown timer.
module tcu_priv_timer_sched
    import tcu_priv_timer_sched_pkg::*;
#(
    // Time-base reset value; nonzero only to exercise wrap-around.
    parameter logic [TIMER_SIZE-1:0] NOW_INIT = '0
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  cfg_valid_i,
    input  logic [SLOT_W-1:0]     cfg_slot_i,
    input  logic [TIMER_SIZE-1:0] cfg_value_i,
    output logic                  cfg_stall_o,
    output logic                  timer_value_valid_o,
    output logic [TIMER_SIZE-1:0] timer_value_o,
    input  logic                  timer_int_valid_i,
    output logic                  timer_int_stall_o,
    output logic                  irq_valid_o,
    output logic [SLOT_W-1:0]     irq_slot_o,
    input  logic                  irq_stall_i
);

    localparam logic signed [TIMER_SIZE-1:0] SLACK_S = TIMER_SIZE'(SLACK);
    localparam logic [TIMER_SIZE-1:0]        STEP    = TIMER_SIZE'(TIMER_FACTOR);

    state_e                       state_q, state_d;
    logic [TIMER_SIZE-1:0]        now_q;
    logic [SLOT_W-1:0]            scan_q;
    logic                         min_valid_q;
    logic [TIMER_SIZE-1:0]        min_dl_q;

    logic                         cfg_take, int_take, exp_en, ack_en, min_upd, irq_load;
    logic                         rd_armed, pend_any;
    logic [TIMER_SIZE-1:0]        rd_deadline;
    logic [SLOT_W-1:0]            pend_lowest;
    logic signed [TIMER_SIZE-1:0] rem, min_rem;

    // Remaining times are signed so deadlines stay comparable across time-base wrap.
    assign rem     = $signed(rd_deadline - now_q);
    assign min_rem = $signed(min_dl_q - now_q);

    tcu_priv_timer_slots u_slots (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .wr_en         (cfg_take),
        .wr_slot       (cfg_slot_i),
        .wr_arm        ((cfg_value_i != VALUE_STOP) && !cfg_value_i[TIMER_SIZE-1]),
        .wr_deadline   (now_q + cfg_value_i),
        .exp_en        (exp_en),
        .exp_slot      (scan_q),
        .ack_en        (ack_en),
        .ack_slot      (irq_slot_o),
        .rd_slot       (scan_q),
        .rd_armed_c    (rd_armed),
        .rd_deadline_c (rd_deadline),
        .pend_any_c    (pend_any),
        .pend_lowest_c (pend_lowest)
    );

    always_comb begin
        state_d  = state_q;
        cfg_take = 1'b0;
        int_take = 1'b0;
        exp_en   = 1'b0;
        ack_en   = 1'b0;
        min_upd  = 1'b0;
        irq_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cfg_take = cfg_valid_i && !cfg_stall_o;
                int_take = timer_int_valid_i && !timer_int_stall_o;
                if (cfg_take || int_take) state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (rd_armed) begin
                    if (rem <= SLACK_S) exp_en = 1'b1;
                    else if (!min_valid_q || (rem < min_rem)) min_upd = 1'b1;
                end
                if (scan_q == SLOT_W'(NUM_SLOTS - 1))
                    state_d = (pend_any || exp_en) ? ST_FIRE : ST_PROGRAM;
            end
            ST_PROGRAM: state_d = ST_IDLE;
            ST_FIRE: begin
                ack_en   = irq_valid_o && !irq_stall_i;
                irq_load = !irq_valid_o || ack_en;
                if (ack_en && !pend_any) state_d = ST_SCAN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q             <= ST_IDLE;
            now_q               <= NOW_INIT;
            scan_q              <= '0;
            min_valid_q         <= 1'b0;
            min_dl_q            <= '0;
            cfg_stall_o         <= 1'b1;
            timer_int_stall_o   <= 1'b1;
            timer_value_valid_o <= 1'b0;
            timer_value_o       <= '0;
            irq_valid_o         <= 1'b0;
            irq_slot_o          <= '0;
        end else begin
            state_q             <= state_d;
            now_q               <= now_q + STEP;
            cfg_stall_o         <= (state_d != ST_IDLE);
            timer_int_stall_o   <= (state_d != ST_IDLE);
            timer_value_valid_o <= (state_q == ST_PROGRAM);
            scan_q              <= (state_q == ST_SCAN) ? scan_q + SLOT_W'(1) : '0;
            // Program value is relative to the time base of the cycle the strobe is seen.
            if (state_q == ST_PROGRAM)
                timer_value_o <= min_valid_q ? min_dl_q - (now_q + STEP) : VALUE_STOP;
            if ((state_q != ST_SCAN) && (state_d == ST_SCAN)) begin
                min_valid_q <= 1'b0;
            end else if (min_upd) begin
                min_valid_q <= 1'b1;
                min_dl_q    <= rd_deadline;
            end
            if (irq_load) begin
                irq_valid_o <= pend_any;
                if (pend_any) irq_slot_o <= pend_lowest;
            end
        end
    end

endmodule
